// File: rtl/wb_retire_monitor.sv
// wb_retire_monitor
// Consumer end of the processor observation interface. Each fetched
// instruction is carried down a delay line matched to the IF->WB depth.
// Every writeback register write then pushes {instruction, cycle stamp}
// into a small FIFO. A host or scoreboard drains the FIFO over a
// valid/ready port. A saturating retired-write counter and a sticky
// overflow flag are maintained alongside.
//
// Optional feature macro: RETIRE_NOP_FILTER_EN
//   defined   - a write whose WB tap is the all-zero NOP is ignored
//               (no record, no overflow effect, no count)
//   undefined - every RegWriteW cycle is recorded
module wb_retire_monitor #(
    parameter int WB_LAT = 4,   // fetch-to-writeback distance, 1..8
    parameter int DEPTH  = 8,   // FIFO entries, power of two, >= 2
    parameter int CYC_W  = 16,  // cycle stamp width
    parameter int CNT_W  = 32   // retired-write counter width
) (
    input  logic                   CLK,
    input  logic                   reset,
    input  logic [31:0]            instruction,
    input  logic                   RegWriteW,
    input  logic                   pipe_hold,
    input  logic                   pipe_flush,
    input  logic                   rec_ready,
    input  logic                   clear_ovf,
    output logic                   rec_valid,
    output logic [31:0]            rec_instr,
    output logic [CYC_W-1:0]       rec_cycle,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic [CNT_W-1:0]       wb_count,
    output logic                   overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] FULL_LVL  = LVL_W'(DEPTH);
    localparam logic [31:0]      NOP_INSTR = 32'h0000_0000;

    // Delay line, stage 0 youngest, stage WB_LAT-1 is in writeback
    logic [31:0]      dly_q [WB_LAT];
    logic [31:0]      dly_d [WB_LAT];
    logic [31:0]      shin_s [WB_LAT];

    // Free-running cycle stamp
    logic [CYC_W-1:0] cyc_q;
    logic [CYC_W-1:0] cyc_d;

    // FIFO storage and bookkeeping
    logic [31:0]      mem_instr_q [DEPTH];
    logic [CYC_W-1:0] mem_cyc_q   [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] rd_ptr_d;
    logic [LVL_W-1:0] lvl_q;
    logic [LVL_W-1:0] lvl_d;

    // Registered head view and status
    logic             valid_q;
    logic             valid_d;
    logic [31:0]      head_instr_q;
    logic [31:0]      head_instr_d;
    logic [CYC_W-1:0] head_cyc_q;
    logic [CYC_W-1:0] head_cyc_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             ovf_q;
    logic             ovf_d;

    // Per-cycle control decisions
    logic [31:0]      tap_s;
    logic             push_req_s;
    logic             pop_s;
    logic             full_s;
    logic             wr_en_s;
    logic             drop_s;
    logic             bypass_s;

    assign tap_s = dly_q[WB_LAT-1];

    // Build the shifted view of the delay line (new fetch enters stage 0)
    always_comb begin
        shin_s[0] = instruction;
        for (int i = 1; i < WB_LAT; i++) begin
            shin_s[i] = dly_q[i-1];
        end
    end

    // Next delay-line contents: flush squashes the two youngest slots after
    // the shift (or in place while held); hold freezes everything else
    always_comb begin
        for (int i = 0; i < WB_LAT; i++) begin
            if (pipe_flush && (i < 2)) begin
                dly_d[i] = NOP_INSTR;
            end else if (pipe_hold) begin
                dly_d[i] = dly_q[i];
            end else begin
                dly_d[i] = shin_s[i];
            end
        end
    end

    // Cycle stamp wraps naturally at 2^CYC_W
    always_comb begin
        cyc_d = cyc_q + CYC_W'(1);
    end

    // Push/pop arbitration, drop detection and overflow next state
    always_comb begin
`ifdef RETIRE_NOP_FILTER_EN
        push_req_s = RegWriteW && (tap_s != NOP_INSTR);
`else
        push_req_s = RegWriteW;
`endif
        full_s  = (lvl_q == FULL_LVL);
        pop_s   = valid_q && rec_ready;
        // A full FIFO still accepts a write when the head leaves this edge
        wr_en_s = push_req_s && (!full_s || pop_s);
        drop_s  = push_req_s && full_s && !pop_s;
        if (drop_s) begin
            ovf_d = 1'b1;
        end else if (clear_ovf) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // Pointer and occupancy next state
    always_comb begin
        if (wr_en_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({wr_en_s, pop_s})
            2'b10:   lvl_d = lvl_q + LVL_W'(1);
            2'b01:   lvl_d = lvl_q - LVL_W'(1);
            default: lvl_d = lvl_q;
        endcase
        valid_d = (lvl_d != '0);
    end

    // Next head view: when the slot becoming head is written on this same
    // edge, take the incoming record directly instead of the stale array
    always_comb begin
        bypass_s = wr_en_s && (wr_ptr_q == rd_ptr_d);
        if (bypass_s) begin
            head_instr_d = tap_s;
            head_cyc_d   = cyc_q;
        end else begin
            head_instr_d = mem_instr_q[rd_ptr_d];
            head_cyc_d   = mem_cyc_q[rd_ptr_d];
        end
    end

    // Retired-write counter saturates at all-ones
    always_comb begin
        if (push_req_s && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Delay line and cycle stamp registers
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < WB_LAT; i++) begin
                dly_q[i] <= 32'h0000_0000;
            end
            cyc_q <= '0;
        end else begin
            for (int i = 0; i < WB_LAT; i++) begin
                dly_q[i] <= dly_d[i];
            end
            cyc_q <= cyc_d;
        end
    end

    // FIFO storage; cleared on reset so no stale record survives
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_instr_q[i] <= 32'h0000_0000;
                mem_cyc_q[i]   <= '0;
            end
        end else if (wr_en_s) begin
            mem_instr_q[wr_ptr_q] <= tap_s;
            mem_cyc_q[wr_ptr_q]   <= cyc_q;
        end
    end

    // FIFO control, head view, counter and overflow registers
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            lvl_q        <= '0;
            valid_q      <= 1'b0;
            head_instr_q <= 32'h0000_0000;
            head_cyc_q   <= '0;
            cnt_q        <= '0;
            ovf_q        <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            lvl_q        <= lvl_d;
            valid_q      <= valid_d;
            head_instr_q <= head_instr_d;
            head_cyc_q   <= head_cyc_d;
            cnt_q        <= cnt_d;
            ovf_q        <= ovf_d;
        end
    end

    assign rec_valid  = valid_q;
    assign rec_instr  = head_instr_q;
    assign rec_cycle  = head_cyc_q;
    assign fifo_level = lvl_q;
    assign wb_count   = cnt_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_wb_retire_monitor.sv
// Self-checking bench for wb_retire_monitor: directed scenarios followed by
// randomized traffic, all checked against a queue-based reference model.
module tb_wb_retire_monitor;

    localparam int WB_LAT = 4;
    localparam int DEPTH  = 8;
    localparam int CYC_W  = 16;
    localparam int CNT_W  = 32;

    logic                   CLK = 1'b0;
    logic                   reset = 1'b0;
    logic [31:0]            instruction = 32'h0;
    logic                   RegWriteW = 1'b0;
    logic                   pipe_hold = 1'b0;
    logic                   pipe_flush = 1'b0;
    logic                   rec_ready = 1'b0;
    logic                   clear_ovf = 1'b0;
    logic                   rec_valid;
    logic [31:0]            rec_instr;
    logic [CYC_W-1:0]       rec_cycle;
    logic [$clog2(DEPTH):0] fifo_level;
    logic [CNT_W-1:0]       wb_count;
    logic                   overflow;

    wb_retire_monitor #(.WB_LAT(WB_LAT), .DEPTH(DEPTH), .CYC_W(CYC_W), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .reset(reset), .instruction(instruction), .RegWriteW(RegWriteW),
        .pipe_hold(pipe_hold), .pipe_flush(pipe_flush), .rec_ready(rec_ready),
        .clear_ovf(clear_ovf), .rec_valid(rec_valid), .rec_instr(rec_instr),
        .rec_cycle(rec_cycle), .fifo_level(fifo_level), .wb_count(wb_count),
        .overflow(overflow)
    );

    always #5 CLK = ~CLK;

    // Reference model: the in-flight pipeline as a queue (index 0 youngest),
    // the record buffer as a queue, plain counters for stamp and writes
    typedef struct packed {
        logic [31:0]      instr;
        logic [CYC_W-1:0] cyc;
    } rec_t;

    logic [31:0]      pipe_m [$];
    rec_t             fifo_m [$];
    logic [CYC_W-1:0] cyc_m;
    logic [CNT_W-1:0] cnt_m;
    logic             ovf_m;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        pipe_m.delete();
        for (int i = 0; i < WB_LAT; i++) pipe_m.push_back(32'h0);
        fifo_m.delete();
        cyc_m = '0;
        cnt_m = '0;
        ovf_m = 1'b0;
    endtask

    // Advance the model by one clock using the inputs currently driven
    task automatic model_step();
        logic [31:0] tap;
        bit pop, push, was_full, drop;
        rec_t r;
        tap      = pipe_m[WB_LAT-1];
        pop      = (fifo_m.size() != 0) && rec_ready;
        push     = RegWriteW;
`ifdef RETIRE_NOP_FILTER_EN
        if (tap == 32'h0) push = 1'b0;
`endif
        was_full = (fifo_m.size() == DEPTH);
        drop     = 1'b0;
        if (push && (cnt_m != {CNT_W{1'b1}})) cnt_m = cnt_m + 1;
        if (pop) void'(fifo_m.pop_front());
        if (push) begin
            if (!was_full || pop) begin
                r.instr = tap;
                r.cyc   = cyc_m;
                fifo_m.push_back(r);
            end else begin
                drop = 1'b1;
            end
        end
        if (drop) ovf_m = 1'b1;
        else if (clear_ovf) ovf_m = 1'b0;
        if (!pipe_hold) begin
            pipe_m.push_front(instruction);
            void'(pipe_m.pop_back());
        end
        if (pipe_flush) begin
            pipe_m[0] = 32'h0;
            if (WB_LAT > 1) pipe_m[1] = 32'h0;
        end
        cyc_m = cyc_m + 1;
    endtask

    task automatic check_outputs();
        chk("valid", rec_valid, fifo_m.size() != 0);
        chk("level", fifo_level, fifo_m.size());
        chk("count", wb_count, cnt_m);
        chk("ovf", overflow, ovf_m);
        if (fifo_m.size() != 0) begin
            chk("head_instr", rec_instr, fifo_m[0].instr);
            chk("head_cycle", rec_cycle, fifo_m[0].cyc);
        end
    endtask

    // One clock: drive at the falling edge, update model, check at next fall
    task automatic cycle(input logic [31:0] ins, input logic rw, input logic hold,
                         input logic flush, input logic rdy, input logic clr);
        instruction = ins;
        RegWriteW   = rw;
        pipe_hold   = hold;
        pipe_flush  = flush;
        rec_ready   = rdy;
        clear_ovf   = clr;
        model_step();
        @(posedge CLK);
        @(negedge CLK);
        check_outputs();
    endtask

    // Asynchronous reset pulse, checked before any clock edge arrives
    task automatic do_reset();
        reset       = 1'b0;
        instruction = 32'h0;
        RegWriteW   = 1'b0;
        pipe_hold   = 1'b0;
        pipe_flush  = 1'b0;
        rec_ready   = 1'b0;
        clear_ovf   = 1'b0;
        #1;
        chk("rst_valid", rec_valid, 1'b0);
        chk("rst_level", fifo_level, 0);
        chk("rst_count", wb_count, 0);
        chk("rst_ovf", overflow, 1'b0);
        chk("rst_instr", rec_instr, 0);
        chk("rst_cycle", rec_cycle, 0);
        model_reset();
        @(negedge CLK);
        reset = 1'b1;
    endtask

    function automatic logic [31:0] rand_nz();
        return $urandom | 32'h1;
    endfunction

    logic [31:0] v [WB_LAT+4];
    logic        pat [5];

    initial begin
        @(negedge CLK);
        do_reset();

        // Idle after reset
        repeat (3) cycle(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("idle_valid", rec_valid, 1'b0);
        chk("idle_count", wb_count, 0);

        // Latency: fetch at cycle 10, write at cycle 10+WB_LAT
        do_reset();
        repeat (10) cycle(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(32'h2008_0005, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (WB_LAT - 1) cycle(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("lat_valid", rec_valid, 1'b1);
        chk("lat_instr", rec_instr, 32'h2008_0005);
        chk("lat_cycle", rec_cycle, 10 + WB_LAT);
        chk("lat_count", wb_count, 1);

        // Hold for two cycles between fetch and writeback
        do_reset();
        cycle(32'h8C09_0004, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(32'hAAAA_0001, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(32'hAAAA_0002, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (WB_LAT - 1) cycle(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("hold_instr", rec_instr, 32'h8C09_0004);
        chk("hold_cycle", rec_cycle, WB_LAT + 2);

        // Flush one cycle after fetch squashes that slot
        do_reset();
        cycle(32'h0109_5020, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(32'h1111_1111, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        repeat (WB_LAT - 2) cycle(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef RETIRE_NOP_FILTER_EN
        chk("flush_valid", rec_valid, 1'b0);
        chk("flush_count", wb_count, 0);
`else
        chk("flush_valid", rec_valid, 1'b1);
        chk("flush_instr", rec_instr, 32'h0);
`endif

        // Overflow: nine writes into eight entries, then push+pop, then clear
        do_reset();
        repeat (WB_LAT) cycle(rand_nz(), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (9) cycle(rand_nz(), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("ovf_level", fifo_level, DEPTH);
        chk("ovf_flag", overflow, 1'b1);
        chk("ovf_count", wb_count, 9);
        cycle(rand_nz(), 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("pushpop_level", fifo_level, DEPTH);
        chk("pushpop_count", wb_count, 10);
        cycle(rand_nz(), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("clr_ovf", overflow, 1'b0);
        chk("clr_level", fifo_level, DEPTH);

        // Reset mid-run with three records held
        do_reset();
        repeat (WB_LAT) cycle(rand_nz(), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) cycle(rand_nz(), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("held3_level", fifo_level, 3);
        do_reset();

        // Drain with back-pressure 1,0,1,1,1
        for (int i = 0; i < WB_LAT + 4; i++) v[i] = rand_nz();
        for (int i = 0; i < WB_LAT + 4; i++)
            cycle(v[i], (i >= WB_LAT), 1'b0, 1'b0, 1'b0, 1'b0);
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b1; pat[3] = 1'b1; pat[4] = 1'b1;
        begin
            int idx;
            idx = 0;
            for (int k = 0; k < 5; k++) begin
                chk("drain_valid", rec_valid, 1'b1);
                chk("drain_head", rec_instr, v[idx]);
                cycle(32'h0, 1'b0, 1'b0, 1'b0, pat[k], 1'b0);
                if (pat[k]) idx++;
            end
        end
        chk("drain_empty", rec_valid, 1'b0);

        // Write on a NOP tap straight after reset
        do_reset();
        cycle(32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef RETIRE_NOP_FILTER_EN
        chk("nop_valid", rec_valid, 1'b0);
        chk("nop_count", wb_count, 0);
`else
        chk("nop_valid", rec_valid, 1'b1);
        chk("nop_instr", rec_instr, 32'h0);
        chk("nop_count", wb_count, 1);
`endif

        // Randomized traffic with alternating back-pressure phases
        do_reset();
        for (int c = 0; c < 900; c++) begin
            if ((c % 300) == 299) begin
                do_reset();
            end else begin
                logic [31:0] ins;
                int rdy_pct;
                ins     = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
                rdy_pct = ((c / 100) % 2 == 1) ? 80 : 25;
                cycle(ins,
                      $urandom_range(0, 99) < 60,
                      $urandom_range(0, 99) < 10,
                      $urandom_range(0, 99) < 8,
                      $urandom_range(0, 99) < rdy_pct,
                      $urandom_range(0, 99) < 5);
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/wb_retire_monitor.md
Name: wb_retire_monitor

Overview:
- Consumer end of the processor's observation interface: takes the fetched `instruction` and `RegWriteW` from `pipeline_processor`.
- Re-aligns each fetched instruction with its writeback cycle using a delay line matched to the pipeline depth.
- Buffers one record (instruction, cycle stamp) per register write in a FIFO, drained over a valid/ready port by a bench scoreboard or debug host.
- Maintains a retired-write counter and a sticky overflow flag.

Parameters:
- WB_LAT, 4, cycles from fetch of `instruction` to its `RegWriteW` in writeback (IF->WB); legal 1..8.
- DEPTH, 8, FIFO entries; power of two, >=2.
- CYC_W, 16, width of the free-running cycle stamp.
- CNT_W, 32, width of the retired-write counter.

Ports:
- CLK  input  1  clock, all state on rising edge.
- reset  input  1  asynchronous, active-low; 0 clears all state immediately.
- instruction  input  32  instruction fetched this cycle by the processor.
- RegWriteW  input  1  writeback stage writes the register file this cycle.
- pipe_hold  input  1  pipeline stalled; delay line frozen.
- pipe_flush  input  1  the two youngest in-flight instructions are squashed.
- rec_ready  input  1  consumer accepts the head record.
- clear_ovf  input  1  clears `overflow`.
- rec_valid  output  1  FIFO non-empty.
- rec_instr  output  32  head record instruction.
- rec_cycle  output  CYC_W  head record cycle stamp.
- fifo_level  output  $clog2(DEPTH)+1  entries held.
- wb_count  output  CNT_W  retired register writes.
- overflow  output  1  sticky: a record was dropped.

Behaviour:
- Reset values (reset=0, asynchronous): all outputs 0; delay line 0x00000000; cycle counter 0; FIFO empty.
- Cycle counter: +1 every clock, wraps at 2^CYC_W.
- Delay line: WB_LAT 32-bit stages, stage 0 youngest.
  - pipe_hold=0: shift, stage 0 <= instruction.
  - pipe_hold=1: contents frozen.
- pipe_flush=1 (pipe_hold=0): after the shift, stage 0 and stage 1 are written 0x00000000 (NOP).
- pipe_flush=1 (pipe_hold=1): stages 0 and 1 zeroed, no shift.
- WB tap: stage WB_LAT-1 is the instruction in writeback this cycle.
- Push: when RegWriteW=1, record {WB tap, cycle counter} is pushed. Both values are sampled before this edge's update.
- Pop: when rec_valid & rec_ready, the head is removed on the edge.
- Head fields: rec_instr and rec_cycle are registered head fields, valid whenever rec_valid=1. They are stable while rec_valid=1 and rec_ready=0.
- Full FIFO with push and pop in the same cycle: both happen, level unchanged.
- Full FIFO with push and no pop: record dropped, overflow <= 1, wb_count still increments.
- Empty FIFO with push: rec_valid=1 the next cycle. There is no fall-through; latency is 1 cycle.
- Pop with rec_valid=0: ignored.
- wb_count: +1 per RegWriteW=1 cycle, saturates at all-ones.
- clear_ovf=1: overflow <= 0. If a drop occurs in the same cycle, overflow <= 1 (set wins).
- fifo_level: exact occupancy, 0..DEPTH.
- Pointers: log2(DEPTH) bits, wrap naturally.
- reset asserted mid-operation: FIFO contents discarded, counters cleared, no partial records.

Optional Feature:
- Macro: RETIRE_NOP_FILTER_EN.
- Defined: a push whose WB tap equals 0x00000000 is suppressed. No FIFO write, no overflow effect, wb_count not incremented.
- Undefined: every RegWriteW=1 cycle pushes, including NOP taps.

Test Plan:
- Reset release, no activity -> rec_valid=0, fifo_level=0, wb_count=0, overflow=0; reset low mid-run with 3 records held -> all cleared immediately.
- Latency check: fetch 0x20080005 at cycle 10, RegWriteW=1 at cycle 14 (WB_LAT=4), rec_ready=0 -> rec_valid=1 at cycle 15 with rec_instr=0x20080005, rec_cycle=14, wb_count=1.
- Hold and flush:
  - pipe_hold=1 for 2 cycles between fetch and WB -> record appears with the matching instruction 2 cycles later.
  - pipe_flush one cycle after fetching 0x01095020 -> WB tap reads 0x00000000 at that slot.
- Overflow: DEPTH=8, rec_ready=0, 9 consecutive RegWriteW=1 -> fifo_level=8, overflow=1, wb_count=9.
  - Then one cycle with push+pop -> level stays 8.
  - Then clear_ovf=1 -> overflow=0.
- Drain with back-pressure: 4 records, rec_ready toggling 1,0,1,1,1 -> records popped in push order, rec_instr stable during ready=0, rec_valid falls after the 4th pop.
- Filter: with RETIRE_NOP_FILTER_EN, RegWriteW=1 on NOP tap -> no record, wb_count unchanged; without the macro -> record with rec_instr=0x00000000, wb_count+1.
